rs_issue_scheduler: RTL and testbench
=====================================

Name: rs_issue_scheduler

Overview:
Allocation and issue controller for the 4-entry tag-based reservation station.
- Tracks which entries are busy and whether each entry's two source operands are ready.
- Accepts dispatches into the lowest free entry.
- Wakes operands on result-tag broadcasts.
- Selects the oldest fully-ready entry for issue each cycle. Its select outputs drive the station's write-enable and read-enable lines.

Parameters:
- NUM_ENTRIES, 4: number of station entries; must be a power of two, 2 to 16.
- TAG_WIDTH, 8: width of the operand and broadcast tags.
- IDX_WIDTH, $clog2(NUM_ENTRIES): width of an entry index and of the age field.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- dispatch_valid, input, 1: new instruction presented for allocation.
- dispatch_ready, output, 1: a free entry exists; equals ~full.
- dispatch_tag0, input, TAG_WIDTH: producer tag of source operand 0.
- dispatch_tag1, input, TAG_WIDTH: producer tag of source operand 1.
- dispatch_rdy0, input, 1: source 0 already valid at dispatch.
- dispatch_rdy1, input, 1: source 1 already valid at dispatch.
- alloc_onehot, output, NUM_ENTRIES: per-entry write-enable for the accepted dispatch.
- bcast_valid, input, 1: a result tag is broadcast this cycle.
- bcast_tag, input, TAG_WIDTH: the broadcast result tag.
- issue_valid, output, 1: an entry is selected for issue.
- issue_onehot, output, NUM_ENTRIES: per-entry read-enable for the selected entry.
- issue_idx, output, IDX_WIDTH: encoded index of the selected entry.
- issue_stall, input, 1: downstream cannot accept; hold the selection.
- occupancy, output, IDX_WIDTH+1: count of busy entries.
- full, output, 1: all entries busy.
- empty, output, 1: no entries busy.
- issue_count, output, 16: perf counter; present only with the optional feature.

Behaviour:
- Per-entry state: busy, rdy0, rdy1, tag0, tag1, and age (IDX_WIDTH bits; 0 = oldest).
- Reset (asynchronous): all busy/rdy/age/tag cleared. Resulting outputs:
  - dispatch_ready=1, full=0, empty=1, occupancy=0.
  - issue_valid=0, issue_onehot=0, issue_idx=0, alloc_onehot=0.
- Reset mid-operation: all entries are discarded immediately; no issue is emitted in the reset cycle.
- Accept rule: accept = dispatch_valid & ~full.
  - alloc_onehot is combinational: the one-hot of the lowest-index non-busy entry, gated by accept.
  - On the edge, that entry sets busy=1 and captures both tags.
- Dispatch-cycle bypass: an allocated entry's rdyN = dispatch_rdyN | (bcast_valid & bcast_tag==dispatch_tagN).
- Wakeup: for every busy entry, if bcast_valid and bcast_tag==tagN, set rdyN on the edge. One broadcast may wake several entries and both operands at once.
- Candidate: busy & rdy0 & rdy1, evaluated from registered state. Consequences:
  - A newly allocated or newly woken entry is eligible at the earliest in the cycle after its update.
  - Dispatch-to-issue minimum latency is 1 cycle.
- Select: the candidate with the smallest age.
  - issue_onehot, issue_idx and issue_valid are combinational from state.
  - issue_onehot is zero when there is no candidate.
- Free rule: free = issue_valid & ~issue_stall.
  - On the edge, the selected entry clears busy, rdy0 and rdy1.
  - While stalled, the selection holds unless an older entry becomes ready. Selection always follows the age rule.
- Age maintenance:
  - On a free, every busy entry with age greater than the freed entry's age decrements.
  - A newly allocated entry takes age = occupancy - free (the current occupancy, minus 1 if an entry frees in the same cycle).
  - The ages of busy entries always form a permutation of 0..occupancy-1.
- Simultaneous dispatch and issue when full: dispatch_ready stays 0; the freed slot cannot be reused in the same cycle.
- Simultaneous dispatch and issue when not full: both occur, occupancy is unchanged, and the ages are applied as above.
- occupancy/full/empty: derived from the registered busy vector.
- Wrap-around: none. Ages are bounded by NUM_ENTRIES-1 by construction.

Optional Feature:
RS_SCHED_PERF_EN
- Defined: 16-bit issue_count increments on each free and wraps from 0xFFFF to 0. It is cleared by rst.
- Undefined: issue_count is tied to 0 and no counter flops are built.

Decomposition:
- Package rs_sched_pkg:
  - NUM_ENTRIES, TAG_WIDTH and IDX_WIDTH constants.
  - rs_entry_t struct {busy, rdy0, rdy1, tag0, tag1, age}.
  - Functions onehot_lowest and onehot_to_idx.
- Sub-module rs_sched_entry: one entry's state, wakeup compares, bypass and age update. It is instantiated NUM_ENTRIES times from a generate loop; allocation, selection and counters stay in the top.

Test Plan:
1. After reset, dispatch tags 0x11/0x22 with rdy0=rdy1=1 → alloc_onehot=0001 in that cycle; next cycle issue_valid=1, issue_idx=0; entry freed, then empty=1.
2. Dispatch entries A(tag0=0x05), B(tag0=0x05), C(tag0=0x09), each with rdy1=1; broadcast 0x05 → A and B become ready next cycle; A issues first (age 0), B issues the following cycle; C is never selected.
3. Fill all 4 entries with rdy=0 → full=1, dispatch_ready=0. Hold dispatch_valid=1 and broadcast one matching tag → that entry issues; dispatch is accepted only in the cycle after the free, and the new entry gets age 3.
4. Two ready entries with issue_stall=1 for 3 cycles → issue_idx held steady and occupancy unchanged. Release the stall → oldest entry freed; ages of the remaining entries decrement.
5. Dispatch with dispatch_tag0=0x3C while bcast_valid=1 and bcast_tag=0x3C (rdy1=1) → entry issues the next cycle (bypass).
6. Assert rst mid-stream with 3 busy entries → occupancy=0 and issue_valid=0 immediately. With RS_SCHED_PERF_EN defined, issue_count reads 0; before the reset it had counted prior frees exactly.

Source files
------------

// File: rtl/rs_sched_pkg.sv
// Shared constants, per-entry state record and one-hot helpers for the reservation-station scheduler.
package rs_sched_pkg;

  localparam int NUM_ENTRIES = 4;
  localparam int TAG_WIDTH   = 8;
  localparam int IDX_WIDTH   = $clog2(NUM_ENTRIES);

  localparam logic [IDX_WIDTH-1:0] AGE_ONE = IDX_WIDTH'(1);

  typedef struct packed {
    logic                 busy;
    logic                 rdy0;
    logic                 rdy1;
    logic [TAG_WIDTH-1:0] tag0;
    logic [TAG_WIDTH-1:0] tag1;
    logic [IDX_WIDTH-1:0] age;
  } rs_entry_t;

  function automatic logic [NUM_ENTRIES-1:0] onehot_lowest(input logic [NUM_ENTRIES-1:0] vec);
    logic [NUM_ENTRIES-1:0] oh;
    oh = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [IDX_WIDTH-1:0] onehot_to_idx(input logic [NUM_ENTRIES-1:0] oh);
    logic [IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (oh[i]) idx = idx | IDX_WIDTH'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_sched_entry.sv
// One station entry: busy/ready/tag/age state with broadcast wakeup and dispatch-cycle bypass.
// State updates one edge after alloc/free/wakeup; candidate is purely registered.
module rs_sched_entry
  import rs_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc,
  input  logic                 sel_free,
  input  logic                 free_vld,
  input  logic [IDX_WIDTH-1:0] free_age,
  input  logic [IDX_WIDTH-1:0] new_age,
  input  logic [TAG_WIDTH-1:0] dispatch_tag0,
  input  logic [TAG_WIDTH-1:0] dispatch_tag1,
  input  logic                 dispatch_rdy0,
  input  logic                 dispatch_rdy1,
  input  logic                 bcast_valid,
  input  logic [TAG_WIDTH-1:0] bcast_tag,
  output logic                 busy,
  output logic                 cand,
  output logic [IDX_WIDTH-1:0] age
);

  rs_entry_t q;
  logic      wake0, wake1, byp0, byp1;

  assign wake0 = bcast_valid && (bcast_tag == q.tag0);
  assign wake1 = bcast_valid && (bcast_tag == q.tag1);
  assign byp0  = dispatch_rdy0 || (bcast_valid && (bcast_tag == dispatch_tag0));
  assign byp1  = dispatch_rdy1 || (bcast_valid && (bcast_tag == dispatch_tag1));

  // alloc only targets idle entries and sel_free only busy ones, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (sel_free) begin
      q.busy <= 1'b0;
      q.rdy0 <= 1'b0;
      q.rdy1 <= 1'b0;
    end else if (alloc) begin
      q.busy <= 1'b1;
      q.rdy0 <= byp0;
      q.rdy1 <= byp1;
      q.tag0 <= dispatch_tag0;
      q.tag1 <= dispatch_tag1;
      q.age  <= new_age;
    end else if (q.busy) begin
      if (wake0) q.rdy0 <= 1'b1;
      if (wake1) q.rdy1 <= 1'b1;
      if (free_vld && (q.age > free_age)) q.age <= q.age - AGE_ONE;
    end
  end

  assign busy = q.busy;
  assign cand = q.busy && q.rdy0 && q.rdy1;
  assign age  = q.age;

endmodule

// File: rtl/rs_issue_scheduler.sv
// Allocation and oldest-ready issue select for the tag-based station; alloc/issue selects are combinational,
// a held issue_stall keeps the entry busy. Optional RS_SCHED_PERF_EN adds the 16-bit issue_count.
module rs_issue_scheduler
  import rs_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic [TAG_WIDTH-1:0]   dispatch_tag0,
  input  logic [TAG_WIDTH-1:0]   dispatch_tag1,
  input  logic                   dispatch_rdy0,
  input  logic                   dispatch_rdy1,
  output logic [NUM_ENTRIES-1:0] alloc_onehot,
  input  logic                   bcast_valid,
  input  logic [TAG_WIDTH-1:0]   bcast_tag,
  output logic                   issue_valid,
  output logic [NUM_ENTRIES-1:0] issue_onehot,
  output logic [IDX_WIDTH-1:0]   issue_idx,
  input  logic                   issue_stall,
  output logic [IDX_WIDTH:0]     occupancy,
  output logic                   full,
  output logic                   empty,
  output logic [15:0]            issue_count
);

  logic [NUM_ENTRIES-1:0] busy_vec, cand_vec, sel_oh;
  logic [IDX_WIDTH-1:0]   ent_age [NUM_ENTRIES];
  logic [IDX_WIDTH-1:0]   best_age, new_age;
  logic                   found, accept, free_vld;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) occupancy = occupancy + (IDX_WIDTH+1)'(busy_vec[i]);
  end

  assign full           = &busy_vec;
  assign empty          = ~|busy_vec;
  assign dispatch_ready = ~full;
  assign accept         = dispatch_valid && !full;
  assign alloc_onehot   = accept ? onehot_lowest(~busy_vec) : '0;

  // Busy ages are a permutation, so the strict compare yields exactly one winner.
  always_comb begin
    found    = 1'b0;
    best_age = '0;
    sel_oh   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cand_vec[i] && (!found || (ent_age[i] < best_age))) begin
        found     = 1'b1;
        best_age  = ent_age[i];
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign issue_valid  = found;
  assign issue_onehot = sel_oh;
  assign issue_idx    = onehot_to_idx(sel_oh);
  assign free_vld     = found && !issue_stall;
  // Accept implies occupancy < NUM_ENTRIES, so the low bits hold the full count here.
  assign new_age      = occupancy[IDX_WIDTH-1:0] - IDX_WIDTH'(free_vld);

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
    rs_sched_entry u_ent (
      .clk           (clk),
      .rst           (rst),
      .alloc         (alloc_onehot[g]),
      .sel_free      (free_vld && sel_oh[g]),
      .free_vld      (free_vld),
      .free_age      (best_age),
      .new_age       (new_age),
      .dispatch_tag0 (dispatch_tag0),
      .dispatch_tag1 (dispatch_tag1),
      .dispatch_rdy0 (dispatch_rdy0),
      .dispatch_rdy1 (dispatch_rdy1),
      .bcast_valid   (bcast_valid),
      .bcast_tag     (bcast_tag),
      .busy          (busy_vec[g]),
      .cand          (cand_vec[g]),
      .age           (ent_age[g])
    );
  end

`ifdef RS_SCHED_PERF_EN
  logic [15:0] issue_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           issue_cnt_q <= '0;
    else if (free_vld) issue_cnt_q <= issue_cnt_q + 16'd1;
  end
  assign issue_count = issue_cnt_q;
`else
  assign issue_count = '0;
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: allocation, wakeup, age-ordered issue, stall, bypass, reset.
module tb_rs_issue_scheduler;
  import rs_sched_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   dispatch_valid, dispatch_ready;
  logic [TAG_WIDTH-1:0]   dispatch_tag0, dispatch_tag1;
  logic                   dispatch_rdy0, dispatch_rdy1;
  logic [NUM_ENTRIES-1:0] alloc_onehot;
  logic                   bcast_valid;
  logic [TAG_WIDTH-1:0]   bcast_tag;
  logic                   issue_valid;
  logic [NUM_ENTRIES-1:0] issue_onehot;
  logic [IDX_WIDTH-1:0]   issue_idx;
  logic                   issue_stall;
  logic [IDX_WIDTH:0]     occupancy;
  logic                   full, empty;
  logic [15:0]            issue_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rs_issue_scheduler dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_tag0(dispatch_tag0), .dispatch_tag1(dispatch_tag1),
    .dispatch_rdy0(dispatch_rdy0), .dispatch_rdy1(dispatch_rdy1),
    .alloc_onehot(alloc_onehot),
    .bcast_valid(bcast_valid), .bcast_tag(bcast_tag),
    .issue_valid(issue_valid), .issue_onehot(issue_onehot), .issue_idx(issue_idx),
    .issue_stall(issue_stall),
    .occupancy(occupancy), .full(full), .empty(empty),
    .issue_count(issue_count)
  );

  // Inputs change 2 time units after the edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_disp(input logic v, input logic [7:0] t0, input logic [7:0] t1,
                            input logic r0, input logic r1);
    dispatch_valid = v;
    dispatch_tag0  = t0;
    dispatch_tag1  = t1;
    dispatch_rdy0  = r0;
    dispatch_rdy1  = r1;
  endtask

  task automatic drive_bcast(input logic v, input logic [7:0] t);
    bcast_valid = v;
    bcast_tag   = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_disp(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive_bcast(1'b0, 8'h00);
    issue_stall = 1'b0;
    #3;
    tests++;
    if ({dispatch_ready, full, empty, occupancy} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      fails++;
      $display("FAIL reset_status: got rdy/full/empty/occ=%b/%b/%b/%0d want 1/0/1/0",
               dispatch_ready, full, empty, occupancy);
    end
    tests++;
    if ({issue_valid, issue_onehot, issue_idx, alloc_onehot} !== 11'd0) begin
      fails++;
      $display("FAIL reset_select: got iv=%b ioh=%b idx=%0d aoh=%b want all zero",
               issue_valid, issue_onehot, issue_idx, alloc_onehot);
    end
    tests++;
    if (issue_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_count: got %0d want 0", issue_count);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    drive_disp(1'b1, 8'h11, 8'h22, 1'b1, 1'b1);
    #1;
    tests++;
    if (alloc_onehot !== 4'b0001 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_alloc: got aoh=%b iv=%b want 0001/0", alloc_onehot, issue_valid);
    end
    tick();
    drive_disp(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    tests++;
    if ({issue_valid, issue_idx, issue_onehot, occupancy} !== {1'b1, 2'd0, 4'b0001, 3'd1}) begin
      fails++;
      $display("FAIL single_issue: got iv=%b idx=%0d oh=%b occ=%0d want 1/0/0001/1",
               issue_valid, issue_idx, issue_onehot, occupancy);
    end
    tick();
    #1;
    tests++;
    if (empty !== 1'b1 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_free: got empty=%b iv=%b want 1/0", empty, issue_valid);
    end
  endtask

  task automatic test_wakeup();
    drive_disp(1'b1, 8'h05, 8'h00, 1'b0, 1'b1); tick();
    drive_disp(1'b1, 8'h05, 8'h00, 1'b0, 1'b1); tick();
    drive_disp(1'b1, 8'h09, 8'h00, 1'b0, 1'b1); tick();
    drive_disp(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive_bcast(1'b1, 8'h05);
    #1;
    tests++;
    if (issue_valid !== 1'b0 || occupancy !== 3'd3) begin
      fails++;
      $display("FAIL wake_same_cycle: got iv=%b occ=%0d want 0/3", issue_valid, occupancy);
    end
    tick();
    drive_bcast(1'b0, 8'h00);
    #1;
    tests++;
    if (issue_valid !== 1'b1 || issue_idx !== 2'd0) begin
      fails++;
      $display("FAIL wake_first: got iv=%b idx=%0d want 1/0", issue_valid, issue_idx);
    end
    tick(); #1;
    tests++;
    if (issue_valid !== 1'b1 || issue_idx !== 2'd1) begin
      fails++;
      $display("FAIL wake_second: got iv=%b idx=%0d want 1/1", issue_valid, issue_idx);
    end
    tick();
    drive_bcast(1'b1, 8'h09);
    #1;
    tests++;
    if (issue_valid !== 1'b0 || occupancy !== 3'd1) begin
      fails++;
      $display("FAIL wake_unmatched: got iv=%b occ=%0d want 0/1", issue_valid, occupancy);
    end
    tick();
    drive_bcast(1'b0, 8'h00);
    #1;
    tests++;
    if (issue_valid !== 1'b1 || issue_idx !== 2'd2) begin
      fails++;
      $display("FAIL wake_cleanup: got iv=%b idx=%0d want 1/2", issue_valid, issue_idx);
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive_disp(1'b1, 8'h40 + 8'(i), 8'h40 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive_disp(1'b1, 8'h43, 8'h43, 1'b0, 1'b0);
    drive_bcast(1'b1, 8'h42);
    #1;
    tests++;
    if ({full, dispatch_ready, occupancy, alloc_onehot} !== {1'b1, 1'b0, 3'd4, 4'b0000}) begin
      fails++;
      $display("FAIL full_status: got full=%b rdy=%b occ=%0d aoh=%b want 1/0/4/0000",
               full, dispatch_ready, occupancy, alloc_onehot);
    end
    tick();
    drive_bcast(1'b0, 8'h00);
    #1;
    tests++;
    if ({issue_valid, issue_idx, alloc_onehot, dispatch_ready} !== {1'b1, 2'd2, 4'b0000, 1'b0}) begin
      fails++;
      $display("FAIL full_issue: got iv=%b idx=%0d aoh=%b rdy=%b want 1/2/0000/0",
               issue_valid, issue_idx, alloc_onehot, dispatch_ready);
    end
    tick(); #1;
    tests++;
    if ({alloc_onehot, dispatch_ready, occupancy} !== {4'b0100, 1'b1, 3'd3}) begin
      fails++;
      $display("FAIL full_realloc: got aoh=%b rdy=%b occ=%0d want 0100/1/3",
               alloc_onehot, dispatch_ready, occupancy);
    end
    tick();
    drive_disp(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive_bcast(1'b1, 8'h43);
    tick();
    drive_bcast(1'b0, 8'h00);
    #1;
    // entry 3 (age 2) must beat the re-allocated entry 2 (age 3)
    tests++;
    if (issue_valid !== 1'b1 || issue_idx !== 2'd3) begin
      fails++;
      $display("FAIL full_new_age: got iv=%b idx=%0d want 1/3", issue_valid, issue_idx);
    end
    tick();
    drive_bcast(1'b1, 8'h40);
    #1;
    tests++;
    if (issue_idx !== 2'd2 || occupancy !== 3'd3) begin
      fails++;
      $display("FAIL full_next: got idx=%0d occ=%0d want 2/3", issue_idx, occupancy);
    end
    tick();
    drive_bcast(1'b1, 8'h41);
    #1;
    tests++;
    if (issue_idx !== 2'd0) begin
      fails++;
      $display("FAIL full_drain0: got idx=%0d want 0", issue_idx);
    end
    tick();
    drive_bcast(1'b0, 8'h00);
    tick(); #1;
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL full_drain: got empty=%b want 1", empty);
    end
  endtask

  task automatic test_stall();
    issue_stall = 1'b1;
    drive_disp(1'b1, 8'h01, 8'h02, 1'b1, 1'b1); tick();
    drive_disp(1'b1, 8'h03, 8'h04, 1'b1, 1'b1); tick();
    drive_disp(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if ({issue_valid, issue_idx, occupancy} !== {1'b1, 2'd0, 3'd2}) begin
        fails++;
        $display("FAIL stall_hold%0d: got iv=%b idx=%0d occ=%0d want 1/0/2",
                 c, issue_valid, issue_idx, occupancy);
      end
      tick();
    end
    issue_stall = 1'b0;
    drive_disp(1'b1, 8'h05, 8'h06, 1'b1, 1'b1);
    #1;
    tests++;
    if (alloc_onehot !== 4'b0100 || issue_idx !== 2'd0) begin
      fails++;
      $display("FAIL stall_release: got aoh=%b idx=%0d want 0100/0", alloc_onehot, issue_idx);
    end
    tick();
    drive_disp(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    tests++;
    if (occupancy !== 3'd2 || issue_idx !== 2'd1) begin
      fails++;
      $display("FAIL stall_age_dec: got occ=%0d idx=%0d want 2/1", occupancy, issue_idx);
    end
    tick(); #1;
    tests++;
    if (issue_valid !== 1'b1 || issue_idx !== 2'd2) begin
      fails++;
      $display("FAIL stall_last: got iv=%b idx=%0d want 1/2", issue_valid, issue_idx);
    end
    tick(); #1;
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL stall_drain: got empty=%b want 1", empty);
    end
  endtask

  task automatic test_bypass();
    drive_disp(1'b1, 8'h3C, 8'h00, 1'b0, 1'b1);
    drive_bcast(1'b1, 8'h3C);
    tick();
    drive_disp(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive_bcast(1'b0, 8'h00);
    #1;
    tests++;
    if (issue_valid !== 1'b1 || issue_onehot !== 4'b0001) begin
      fails++;
      $display("FAIL bypass_issue: got iv=%b oh=%b want 1/0001", issue_valid, issue_onehot);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [15:0] exp_cnt;
`ifdef RS_SCHED_PERF_EN
    exp_cnt = 16'd13;
`else
    exp_cnt = 16'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      drive_disp(1'b1, 8'h90 + 8'(i), 8'h90, 1'b0, 1'b0);
      tick();
    end
    drive_disp(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    tests++;
    if (occupancy !== 3'd3 || issue_count !== exp_cnt) begin
      fails++;
      $display("FAIL pre_reset: got occ=%0d cnt=%0d want 3/%0d", occupancy, issue_count, exp_cnt);
    end
    rst = 1'b1;
    drive_bcast(1'b1, 8'h90);
    #1;
    tests++;
    if ({occupancy, issue_valid, empty, issue_count} !== {3'd0, 1'b0, 1'b1, 16'd0}) begin
      fails++;
      $display("FAIL mid_reset: got occ=%0d iv=%b empty=%b cnt=%0d want 0/0/1/0",
               occupancy, issue_valid, empty, issue_count);
    end
    tick();
    drive_bcast(1'b0, 8'h00);
    rst = 1'b0;
    tick(); #1;
    tests++;
    if (dispatch_ready !== 1'b1 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: got rdy=%b iv=%b want 1/0", dispatch_ready, issue_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wakeup();
    test_full();
    test_stall();
    test_bypass();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
